// File: rtl/hazard_fwd_ctrl.sv
// Hazard and forwarding controller for the decode/execute pipeline.
//
// Picks a forward source for each decode operand (youngest match wins), detects
// load-use hazards on the youngest source, interlocks decode against a busy
// matrix unit, stretches a taken branch into a multi-cycle flush and keeps
// saturating stall/flush event counters.
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   d_valid_i                    decode holds a valid instruction
//   d_op{1,2}_reg_i/_used_i      decode source registers and whether each is read
//   d_mm_start_i, d_mm_use_i     decode starts / touches the matrix unit
//   src_*_i                      per forwarding source: dest, wr_en, valid, is_load, data
//   br_taken_i                   execute resolved a taken branch
//   fwd{1,2}_sel_o/_data_o       forward mux select (0 = regfile, k+1 = source k) and data
//   stall_o, flush_o             pipeline control
//   mm_busy_o                    matrix unit busy
//   stall_cnt_o, flush_cnt_o     saturating performance counters
module hazard_fwd_ctrl #(
  parameter int unsigned NUM_SRC      = 3,
  parameter int unsigned REG_W        = 5,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned MM_LATENCY   = 8,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned SEL_W        = $clog2(NUM_SRC + 1)
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        d_valid_i,
  input  logic [REG_W-1:0]            d_op1_reg_i,
  input  logic [REG_W-1:0]            d_op2_reg_i,
  input  logic                        d_op1_used_i,
  input  logic                        d_op2_used_i,
  input  logic                        d_mm_start_i,
  input  logic                        d_mm_use_i,
  input  logic [NUM_SRC*REG_W-1:0]    src_dest_reg_i,
  input  logic [NUM_SRC-1:0]          src_wr_en_i,
  input  logic [NUM_SRC-1:0]          src_valid_i,
  input  logic [NUM_SRC-1:0]          src_is_load_i,
  input  logic [NUM_SRC*DATA_W-1:0]   src_data_i,
  input  logic                        br_taken_i,
  output logic [SEL_W-1:0]            fwd1_sel_o,
  output logic [SEL_W-1:0]            fwd2_sel_o,
  output logic [DATA_W-1:0]           fwd1_data_o,
  output logic [DATA_W-1:0]           fwd2_data_o,
  output logic                        stall_o,
  output logic                        flush_o,
  output logic                        mm_busy_o,
  output logic [31:0]                 stall_cnt_o,
  output logic [31:0]                 flush_cnt_o
);

  localparam int unsigned BusyW  = $clog2(MM_LATENCY + 1);
  localparam int unsigned FlushW = $clog2(FLUSH_CYCLES + 1);

  logic [NUM_SRC-1:0] match1, match2;
  logic               load_use, mm_stall, mm_accept;
  logic [BusyW-1:0]   busy_q, busy_d;
  logic [FlushW-1:0]  flush_q, flush_d;
  logic [31:0]        stall_cnt_q, stall_cnt_d;
  logic [31:0]        flush_cnt_q, flush_cnt_d;

  // Per-source operand match; register 0 is never a forwarding target.
  always_comb begin
    match1 = '0;
    match2 = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      logic [REG_W-1:0] dest;
      dest = src_dest_reg_i[k*REG_W +: REG_W];
      match1[k] = src_valid_i[k] & src_wr_en_i[k] & d_op1_used_i &
                  (dest == d_op1_reg_i) & (dest != '0);
      match2[k] = src_valid_i[k] & src_wr_en_i[k] & d_op2_used_i &
                  (dest == d_op2_reg_i) & (dest != '0);
    end
  end

  // Scan oldest to youngest so the lowest-index match overwrites last.
  always_comb begin
    fwd1_sel_o  = '0;
    fwd2_sel_o  = '0;
    fwd1_data_o = '0;
    fwd2_data_o = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      if (match1[k]) begin
        fwd1_sel_o  = SEL_W'(k + 1);
        fwd1_data_o = src_data_i[k*DATA_W +: DATA_W];
      end
      if (match2[k]) begin
        fwd2_sel_o  = SEL_W'(k + 1);
        fwd2_data_o = src_data_i[k*DATA_W +: DATA_W];
      end
    end
  end

  // A match on source 0 always wins, so it alone decides load-use.
  assign load_use  = (match1[0] | match2[0]) & src_is_load_i[0];
  assign mm_stall  = d_valid_i & (d_mm_start_i | d_mm_use_i) & (busy_q != '0);
  assign flush_o   = (flush_q != '0);
  assign stall_o   = (load_use | mm_stall) & ~flush_o;
  assign mm_busy_o = (busy_q != '0);
  assign mm_accept = d_valid_i & d_mm_start_i & ~stall_o & ~flush_o;

  always_comb begin
    busy_d = busy_q;
    if (mm_accept) begin
      busy_d = BusyW'(MM_LATENCY);
    end else if (busy_q != '0) begin
      busy_d = busy_q - 1'b1;
    end

    // A new branch reloads rather than accumulates.
    flush_d = flush_q;
    if (br_taken_i) begin
      flush_d = FlushW'(FLUSH_CYCLES);
    end else if (flush_q != '0) begin
      flush_d = flush_q - 1'b1;
    end

    stall_cnt_d = stall_cnt_q;
    if (stall_o && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end

    flush_cnt_d = flush_cnt_q;
    if (flush_o && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q      <= '0;
      flush_q     <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      busy_q      <= busy_d;
      flush_q     <= flush_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Self-checking bench for hazard_fwd_ctrl: table of forwarding/load-use vectors
// plus hand-written sequences for reset, matrix interlock, flush and saturation.
module tb_hazard_fwd_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        d_valid, d_op1_used, d_op2_used, d_mm_start, d_mm_use, br_taken;
  logic [4:0]  d_op1_reg, d_op2_reg;
  logic [14:0] src_dest_reg;
  logic [2:0]  src_wr_en, src_valid, src_is_load;
  logic [95:0] src_data;
  logic [1:0]  fwd1_sel, fwd2_sel;
  logic [31:0] fwd1_data, fwd2_data;
  logic        stall, flush, mm_busy;
  logic [31:0] stall_cnt, flush_cnt;

  int n_vec = 0;
  int n_err = 0;
  int exp_stalls;

  always #5 clk = ~clk;

  hazard_fwd_ctrl dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .d_valid_i      (d_valid),
    .d_op1_reg_i    (d_op1_reg),
    .d_op2_reg_i    (d_op2_reg),
    .d_op1_used_i   (d_op1_used),
    .d_op2_used_i   (d_op2_used),
    .d_mm_start_i   (d_mm_start),
    .d_mm_use_i     (d_mm_use),
    .src_dest_reg_i (src_dest_reg),
    .src_wr_en_i    (src_wr_en),
    .src_valid_i    (src_valid),
    .src_is_load_i  (src_is_load),
    .src_data_i     (src_data),
    .br_taken_i     (br_taken),
    .fwd1_sel_o     (fwd1_sel),
    .fwd2_sel_o     (fwd2_sel),
    .fwd1_data_o    (fwd1_data),
    .fwd2_data_o    (fwd2_data),
    .stall_o        (stall),
    .flush_o        (flush),
    .mm_busy_o      (mm_busy),
    .stall_cnt_o    (stall_cnt),
    .flush_cnt_o    (flush_cnt)
  );

  typedef struct {
    logic [4:0]  op1, op2;
    logic        u1, u2;
    logic [4:0]  d0, d1, d2;
    logic [2:0]  wr, vld, ld;
    logic [1:0]  s1, s2;
    logic [31:0] x1, x2;
    logic        st;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle();
    d_valid = 1'b0; d_op1_reg = '0; d_op2_reg = '0; d_op1_used = 1'b0; d_op2_used = 1'b0;
    d_mm_start = 1'b0; d_mm_use = 1'b0; br_taken = 1'b0;
    src_dest_reg = '0; src_wr_en = '0; src_valid = '0; src_is_load = '0;
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Source 0 is a load to x7 and op2 reads x7.
  task automatic set_load_use();
    d_valid = 1'b1; d_op2_reg = 5'd7; d_op2_used = 1'b1;
    src_dest_reg = {5'd0, 5'd0, 5'd7}; src_wr_en = 3'b001; src_valid = 3'b001;
    src_is_load = 3'b001;
  endtask

  initial begin
    src_data = {32'h33, 32'h22, 32'h11};
    rst = 1'b1;
    idle();
    tick();
    rst = 1'b0;

    // Random activity, then a single reset edge must clear everything.
    for (int i = 0; i < 6; i++) begin
      d_valid = 1'($urandom); d_op1_reg = 5'($urandom); d_op2_reg = 5'($urandom);
      d_op1_used = 1'($urandom); d_op2_used = 1'($urandom);
      d_mm_start = 1'b1; d_mm_use = 1'($urandom); br_taken = 1'($urandom);
      src_dest_reg = 15'($urandom); src_wr_en = 3'($urandom); src_valid = 3'($urandom);
      src_is_load = 3'($urandom);
      tick();
    end
    br_taken = 1'b1;
    do_reset();
    idle();
    #3;
    check("rst_mm_busy", 64'(mm_busy), 64'd0);
    check("rst_flush", 64'(flush), 64'd0);
    check("rst_stall_cnt", 64'(stall_cnt), 64'd0);
    check("rst_flush_cnt", 64'(flush_cnt), 64'd0);
    check("rst_stall", 64'(stall), 64'd0);
    tick();

    // op1, op2, u1, u2, d0, d1, d2, wr, vld, ld, s1, s2, x1, x2, stall
    vecs[0]  = '{5'd5,  5'd0, 1, 0, 5'd5,  5'd9, 5'd5, 3'b111, 3'b111, 3'b000, 2'd1, 2'd0,
                 32'h11, 32'h0,  1'b0};
    vecs[1]  = '{5'd0,  5'd0, 1, 1, 5'd0,  5'd0, 5'd0, 3'b111, 3'b111, 3'b000, 2'd0, 2'd0,
                 32'h0,  32'h0,  1'b0};
    vecs[2]  = '{5'd1,  5'd7, 1, 1, 5'd7,  5'd2, 5'd3, 3'b111, 3'b111, 3'b001, 2'd0, 2'd1,
                 32'h0,  32'h11, 1'b1};
    vecs[3]  = '{5'd1,  5'd7, 1, 1, 5'd3,  5'd7, 5'd7, 3'b111, 3'b111, 3'b010, 2'd0, 2'd2,
                 32'h0,  32'h22, 1'b0};
    vecs[4]  = '{5'd5,  5'd5, 0, 0, 5'd5,  5'd5, 5'd5, 3'b111, 3'b111, 3'b000, 2'd0, 2'd0,
                 32'h0,  32'h0,  1'b0};
    vecs[5]  = '{5'd5,  5'd5, 1, 1, 5'd5,  5'd5, 5'd0, 3'b110, 3'b111, 3'b000, 2'd2, 2'd2,
                 32'h22, 32'h22, 1'b0};
    vecs[6]  = '{5'd9,  5'd9, 1, 0, 5'd9,  5'd9, 5'd9, 3'b111, 3'b100, 3'b000, 2'd3, 2'd0,
                 32'h33, 32'h0,  1'b0};
    vecs[7]  = '{5'd7,  5'd7, 0, 0, 5'd7,  5'd0, 5'd0, 3'b111, 3'b111, 3'b001, 2'd0, 2'd0,
                 32'h0,  32'h0,  1'b0};
    vecs[8]  = '{5'd4,  5'd6, 1, 1, 5'd1,  5'd6, 5'd4, 3'b111, 3'b111, 3'b000, 2'd3, 2'd2,
                 32'h33, 32'h22, 1'b0};
    vecs[9]  = '{5'd0,  5'd0, 1, 1, 5'd0,  5'd0, 5'd0, 3'b111, 3'b111, 3'b111, 2'd0, 2'd0,
                 32'h0,  32'h0,  1'b0};
    vecs[10] = '{5'd12, 5'd3, 1, 1, 5'd12, 5'd3, 5'd0, 3'b111, 3'b111, 3'b001, 2'd1, 2'd2,
                 32'h11, 32'h22, 1'b1};

    exp_stalls = 0;
    for (int i = 0; i < 11; i++) begin
      d_valid = 1'b1;
      d_op1_reg = vecs[i].op1; d_op2_reg = vecs[i].op2;
      d_op1_used = vecs[i].u1; d_op2_used = vecs[i].u2;
      src_dest_reg = {vecs[i].d2, vecs[i].d1, vecs[i].d0};
      src_wr_en = vecs[i].wr; src_valid = vecs[i].vld; src_is_load = vecs[i].ld;
      #3;
      check($sformatf("v%0d_sel1", i), 64'(fwd1_sel), 64'(vecs[i].s1));
      check($sformatf("v%0d_sel2", i), 64'(fwd2_sel), 64'(vecs[i].s2));
      check($sformatf("v%0d_data1", i), 64'(fwd1_data), 64'(vecs[i].x1));
      check($sformatf("v%0d_data2", i), 64'(fwd2_data), 64'(vecs[i].x2));
      check($sformatf("v%0d_stall", i), 64'(stall), 64'(vecs[i].st));
      if (vecs[i].st) exp_stalls++;
      tick();
    end
    idle();
    #3;
    check("table_stall_cnt", 64'(stall_cnt), 64'(exp_stalls));

    // Matrix interlock: accept at cycle 0, busy for cycles 1..8.
    do_reset();
    d_valid = 1'b1; d_mm_start = 1'b1;
    #3;
    check("mm_c0_stall", 64'(stall), 64'd0);
    check("mm_c0_busy", 64'(mm_busy), 64'd0);
    tick();
    for (int c = 1; c <= 9; c++) begin
      idle();
      if (c == 4 || c == 9) begin
        d_valid = 1'b1; d_mm_use = 1'b1;
      end
      #3;
      check($sformatf("mm_c%0d_busy", c), 64'(mm_busy), 64'(c <= 8));
      if (c == 4 || c == 9) check($sformatf("mm_c%0d_stall", c), 64'(stall), 64'(c == 4));
      tick();
    end
    idle();

    // Branch flush over a pending load-use hazard, with a second branch at cycle 1.
    do_reset();
    set_load_use(); br_taken = 1'b1;
    #3;
    check("fl_c0_flush", 64'(flush), 64'd0);
    check("fl_c0_stall", 64'(stall), 64'd1);
    tick();
    #3;
    check("fl_c1_flush", 64'(flush), 64'd1);
    check("fl_c1_stall", 64'(stall), 64'd0);
    tick();
    br_taken = 1'b0; d_mm_start = 1'b1;
    #3;
    check("fl_c2_flush", 64'(flush), 64'd1);
    check("fl_c2_stall", 64'(stall), 64'd0);
    tick();
    d_mm_start = 1'b0;
    #3;
    check("fl_c3_flush", 64'(flush), 64'd1);
    check("fl_c3_stall", 64'(stall), 64'd0);
    check("fl_c3_no_mm_accept", 64'(mm_busy), 64'd0);
    tick();
    #3;
    check("fl_c4_flush", 64'(flush), 64'd0);
    check("fl_c4_stall", 64'(stall), 64'd1);
    idle();
    tick();
    check("fl_flush_cnt", 64'(flush_cnt), 64'd3);

    // Saturation of both counters, preloaded close to the top.
    do_reset();
    force dut.stall_cnt_q = 32'hFFFF_FFFD;
    force dut.flush_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.stall_cnt_q;
    release dut.flush_cnt_q;
    set_load_use();
    tick();
    check("sat_stall_1", 64'(stall_cnt), 64'hFFFF_FFFE);
    tick();
    check("sat_stall_2", 64'(stall_cnt), 64'hFFFF_FFFF);
    br_taken = 1'b1;
    tick();
    check("sat_stall_3", 64'(stall_cnt), 64'hFFFF_FFFF);
    br_taken = 1'b0;
    tick();
    check("sat_flush_1", 64'(flush_cnt), 64'hFFFF_FFFF);
    tick();
    check("sat_flush_2", 64'(flush_cnt), 64'hFFFF_FFFF);
    idle();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
